gpio_core_v2: RTL and testbench

- Parametrised next-generation GPIO core, 1 to 32 pins.
- Adds a pad input synchroniser, per-pin optional debounce, four interrupt modes per pin with W1C sticky status, atomic set/clear of output bits, and two-way alternate-function muxing.
- Sits behind the APB4 bridge on a simple word-addressed register port; pad-side signals go to the IO ring and the pinmux fabric.

---
 rtl/gpio_core_v2.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_gpio_core_v2.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_core_v2.sv
`default_nettype none
// ============================================================================
// Module   : gpio_core_v2
// Purpose  : Parametrised GPIO core (1..32 pins). Provides a pad input
//            synchroniser, optional per-pin debounce, four interrupt modes per
//            pin with W1C sticky status, atomic output set/clear and a
//            two-way alternate-function output mux.
// Options  : GPIO_DEBOUNCE_EN - when defined, adds the debounce prescaler,
//            per-pin debounce counters and the DBEN/DBDIV registers. When
//            undefined, DBEN/DBDIV read 0 and pads bypass straight through
//            the synchroniser.
// Ports    : clk_i, rst_i (async, active-high)
//            reg_en_i/reg_we_i/reg_addr_i/reg_wdata_i/reg_rdata_o - register
//              port, word indexed, read data combinational from reg_addr_i
//            gpio_in_i     - raw asynchronous pad inputs
//            gpio_out_o    - pad output value
//            gpio_dir_o    - pad direction, 1 = output
//            gpio_alt_in_o - conditioned input to alternate functions
//            gpio_alt_{0,1}_{out,dir}_i - alternate function drive
//            irq_o         - interrupt request
// Revision : 1.0 - initial release
// ============================================================================
module gpio_core_v2 #(
    parameter int GPIO_NUM    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CNT      = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                reg_en_i,
    input  logic                reg_we_i,
    input  logic [3:0]          reg_addr_i,
    input  logic [31:0]         reg_wdata_i,
    output logic [31:0]         reg_rdata_o,
    input  logic [GPIO_NUM-1:0] gpio_in_i,
    output logic [GPIO_NUM-1:0] gpio_out_o,
    output logic [GPIO_NUM-1:0] gpio_dir_o,
    output logic [GPIO_NUM-1:0] gpio_alt_in_o,
    input  logic [GPIO_NUM-1:0] gpio_alt_0_out_i,
    input  logic [GPIO_NUM-1:0] gpio_alt_0_dir_i,
    input  logic [GPIO_NUM-1:0] gpio_alt_1_out_i,
    input  logic [GPIO_NUM-1:0] gpio_alt_1_dir_i,
    output logic                irq_o
);

    // ------------------------------------------------------------------
    // Register indices
    // ------------------------------------------------------------------
    localparam logic [3:0] c_ADDR_PADDIR   = 4'd0;
    localparam logic [3:0] c_ADDR_PADIN    = 4'd1;
    localparam logic [3:0] c_ADDR_PADOUT   = 4'd2;
    localparam logic [3:0] c_ADDR_INTEN    = 4'd3;
    localparam logic [3:0] c_ADDR_INTTYPE0 = 4'd4;
    localparam logic [3:0] c_ADDR_INTTYPE1 = 4'd5;
    localparam logic [3:0] c_ADDR_INTSTAT  = 4'd6;
    localparam logic [3:0] c_ADDR_IOFCFG   = 4'd7;
    localparam logic [3:0] c_ADDR_PINMUX   = 4'd8;
    localparam logic [3:0] c_ADDR_OUTSET   = 4'd9;
    localparam logic [3:0] c_ADDR_OUTCLR   = 4'd10;
`ifdef GPIO_DEBOUNCE_EN
    localparam logic [3:0] c_ADDR_DBEN     = 4'd11;
    localparam logic [3:0] c_ADDR_DBDIV    = 4'd12;
`endif

    // ------------------------------------------------------------------
    // Register write decode
    // ------------------------------------------------------------------
    logic                w_wr;
    logic [GPIO_NUM-1:0] w_wdata;
    logic                w_unused_wdata;

    assign w_wr    = reg_en_i & reg_we_i;
    assign w_wdata = reg_wdata_i[GPIO_NUM-1:0];
    // Upper write-data bits are architecturally ignored for narrow builds.
    assign w_unused_wdata = ^reg_wdata_i;

    logic [GPIO_NUM-1:0] r_paddir;
    logic [GPIO_NUM-1:0] r_padout;
    logic [GPIO_NUM-1:0] r_inten;
    logic [GPIO_NUM-1:0] r_inttype0;
    logic [GPIO_NUM-1:0] r_inttype1;
    logic [GPIO_NUM-1:0] r_intstat;
    logic [GPIO_NUM-1:0] r_iofcfg;
    logic [GPIO_NUM-1:0] r_pinmux;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_paddir   <= '0;
            r_padout   <= '0;
            r_inten    <= '0;
            r_inttype0 <= '0;
            r_inttype1 <= '0;
            r_iofcfg   <= '0;
            r_pinmux   <= '0;
        end else if (w_wr) begin
            case (reg_addr_i)
                c_ADDR_PADDIR:   r_paddir   <= w_wdata;
                c_ADDR_PADOUT:   r_padout   <= w_wdata;
                c_ADDR_OUTSET:   r_padout   <= r_padout | w_wdata;
                c_ADDR_OUTCLR:   r_padout   <= r_padout & ~w_wdata;
                c_ADDR_INTEN:    r_inten    <= w_wdata;
                c_ADDR_INTTYPE0: r_inttype0 <= w_wdata;
                c_ADDR_INTTYPE1: r_inttype1 <= w_wdata;
                c_ADDR_IOFCFG:   r_iofcfg   <= w_wdata;
                c_ADDR_PINMUX:   r_pinmux   <= w_wdata;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pad input synchroniser
    // ------------------------------------------------------------------
    logic [GPIO_NUM-1:0] r_sync [SYNC_STAGES];
    logic [GPIO_NUM-1:0] w_sync;
    logic [GPIO_NUM-1:0] w_cin;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= gpio_in_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    // ------------------------------------------------------------------
    // Debounce: shared prescaler plus one saturating agreement counter per
    // pin. A pin's accepted value only changes after the synchronised level
    // has differed from it on DB_CNT consecutive prescaler ticks.
    // ------------------------------------------------------------------
    localparam int                c_DB_W    = $clog2(DB_CNT + 1);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DB_CNT - 1);

    logic [GPIO_NUM-1:0] r_dben;
    logic [15:0]         r_dbdiv;
    logic [15:0]         r_pre;
    logic                w_tick;
    logic [GPIO_NUM-1:0] r_db;
    logic [c_DB_W-1:0]   r_db_cnt [GPIO_NUM];

    assign w_tick = (r_pre == r_dbdiv);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dben  <= '0;
            r_dbdiv <= '0;
        end else if (w_wr) begin
            if (reg_addr_i == c_ADDR_DBEN) begin
                r_dben <= w_wdata;
            end
            if (reg_addr_i == c_ADDR_DBDIV) begin
                r_dbdiv <= reg_wdata_i[15:0];
            end
        end
    end

    // A DBDIV write restarts the period so the new divider applies cleanly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pre <= '0;
        end else if (w_wr && (reg_addr_i == c_ADDR_DBDIV)) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_db <= '0;
            for (int p = 0; p < GPIO_NUM; p++) begin
                r_db_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < GPIO_NUM; p++) begin
                if (!r_dben[p]) begin
                    // Track the live level while bypassed so enabling
                    // debounce later does not expose a stale value.
                    r_db[p]     <= w_sync[p];
                    r_db_cnt[p] <= '0;
                end else if (w_sync[p] == r_db[p]) begin
                    r_db_cnt[p] <= '0;
                end else if (w_tick) begin
                    if (r_db_cnt[p] == c_DB_LAST) begin
                        r_db[p]     <= w_sync[p];
                        r_db_cnt[p] <= '0;
                    end else begin
                        r_db_cnt[p] <= r_db_cnt[p] + c_DB_W'(1);
                    end
                end
            end
        end
    end

    assign w_cin = (r_dben & r_db) | (~r_dben & w_sync);
`else
    assign w_cin = w_sync;
`endif

    assign gpio_alt_in_o = w_cin;

    // ------------------------------------------------------------------
    // Interrupt detection. The history register runs regardless of mode,
    // so a change of INTTYPE never manufactures an edge by itself.
    // ------------------------------------------------------------------
    logic [GPIO_NUM-1:0] r_hist;
    logic [GPIO_NUM-1:0] w_rise;
    logic [GPIO_NUM-1:0] w_fall;
    logic [GPIO_NUM-1:0] w_cond;
    logic [GPIO_NUM-1:0] w_set;
    logic [GPIO_NUM-1:0] w_w1c;

    assign w_rise = w_cin & ~r_hist;
    assign w_fall = ~w_cin & r_hist;

    always_comb begin
        w_cond = '0;
        for (int p = 0; p < GPIO_NUM; p++) begin
            case ({r_inttype1[p], r_inttype0[p]})
                2'b00:   w_cond[p] = w_cin[p];
                2'b01:   w_cond[p] = ~w_cin[p];
                2'b10:   w_cond[p] = w_rise[p];
                default: w_cond[p] = w_fall[p];
            endcase
        end
    end

    assign w_set = w_cond & r_inten;
    assign w_w1c = (w_wr && (reg_addr_i == c_ADDR_INTSTAT)) ? w_wdata : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hist    <= '0;
            r_intstat <= '0;
        end else begin
            r_hist    <= w_cin;
            // A set in the same cycle as a W1C takes priority.
            r_intstat <= (r_intstat & ~w_w1c) | w_set;
        end
    end

    // Both operands are flops, so irq_o has no path from any input.
    assign irq_o = |(r_intstat & r_inten);

    // ------------------------------------------------------------------
    // Output / direction mux
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < GPIO_NUM; gi++) begin : g_pin
        assign gpio_out_o[gi] = r_iofcfg[gi] ?
                                (r_pinmux[gi] ? gpio_alt_1_out_i[gi] : gpio_alt_0_out_i[gi]) :
                                r_padout[gi];
        assign gpio_dir_o[gi] = r_iofcfg[gi] ?
                                (r_pinmux[gi] ? gpio_alt_1_dir_i[gi] : gpio_alt_0_dir_i[gi]) :
                                r_paddir[gi];
    end

    // ------------------------------------------------------------------
    // Read mux (write-only and unmapped indices read 0)
    // ------------------------------------------------------------------
    always_comb begin
        reg_rdata_o = '0;
        case (reg_addr_i)
            c_ADDR_PADDIR:   reg_rdata_o = 32'(r_paddir);
            c_ADDR_PADIN:    reg_rdata_o = 32'(w_cin);
            c_ADDR_PADOUT:   reg_rdata_o = 32'(r_padout);
            c_ADDR_INTEN:    reg_rdata_o = 32'(r_inten);
            c_ADDR_INTTYPE0: reg_rdata_o = 32'(r_inttype0);
            c_ADDR_INTTYPE1: reg_rdata_o = 32'(r_inttype1);
            c_ADDR_INTSTAT:  reg_rdata_o = 32'(r_intstat);
            c_ADDR_IOFCFG:   reg_rdata_o = 32'(r_iofcfg);
            c_ADDR_PINMUX:   reg_rdata_o = 32'(r_pinmux);
`ifdef GPIO_DEBOUNCE_EN
            c_ADDR_DBEN:     reg_rdata_o = 32'(r_dben);
            c_ADDR_DBDIV:    reg_rdata_o = 32'(r_dbdiv);
`endif
            default:         reg_rdata_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_gpio_core_v2.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_core_v2
// Purpose  : Self-checking bench for gpio_core_v2: table of register
//            write/read vectors, then hand-written interrupt, pin-mux and
//            (with GPIO_DEBOUNCE_EN) debounce sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_core_v2;

    localparam int GPIO_NUM    = 8;
    localparam int SYNC_STAGES = 2;
    localparam int DB_CNT      = 4;

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [31:0] c_DBEN_RD  = 32'h0000_00FF;
    localparam logic [31:0] c_DBDIV_RD = 32'h0000_1234;
`else
    localparam logic [31:0] c_DBEN_RD  = 32'h0;
    localparam logic [31:0] c_DBDIV_RD = 32'h0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                reg_en = 1'b0;
    logic                reg_we = 1'b0;
    logic [3:0]          reg_addr = '0;
    logic [31:0]         reg_wdata = '0;
    logic [31:0]         reg_rdata;
    logic [GPIO_NUM-1:0] gpio_in = '0;
    logic [GPIO_NUM-1:0] gpio_out;
    logic [GPIO_NUM-1:0] gpio_dir;
    logic [GPIO_NUM-1:0] gpio_alt_in;
    logic [GPIO_NUM-1:0] alt0_out = '0;
    logic [GPIO_NUM-1:0] alt0_dir = '0;
    logic [GPIO_NUM-1:0] alt1_out = '0;
    logic [GPIO_NUM-1:0] alt1_dir = '0;
    logic                irq;

    always #5 clk = ~clk;

    gpio_core_v2 #(
        .GPIO_NUM   (GPIO_NUM),
        .SYNC_STAGES(SYNC_STAGES),
        .DB_CNT     (DB_CNT)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .reg_en_i        (reg_en),
        .reg_we_i        (reg_we),
        .reg_addr_i      (reg_addr),
        .reg_wdata_i     (reg_wdata),
        .reg_rdata_o     (reg_rdata),
        .gpio_in_i       (gpio_in),
        .gpio_out_o      (gpio_out),
        .gpio_dir_o      (gpio_dir),
        .gpio_alt_in_o   (gpio_alt_in),
        .gpio_alt_0_out_i(alt0_out),
        .gpio_alt_0_dir_i(alt0_dir),
        .gpio_alt_1_out_i(alt1_out),
        .gpio_alt_1_dir_i(alt1_dir),
        .irq_o           (irq)
    );

    typedef struct {
        bit          do_wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input bit w, input logic [3:0] a, input logic [31:0] d,
                       input logic [31:0] e);
        vec_t v;
        v.do_wr = w;
        v.addr  = a;
        v.wdata = d;
        v.exp   = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_en    = 1'b1;
        reg_we    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        @(negedge clk);
        reg_en    = 1'b0;
        reg_we    = 1'b0;
        reg_wdata = '0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        reg_addr = a;
        #1;
        d = reg_rdata;
    endtask

    task automatic rd_check(input string name, input logic [3:0] a,
                            input logic [31:0] e);
        logic [31:0] v;
        rd(a, v);
        check(name, v, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int          seen;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_gpio_out", 32'(gpio_out), 32'h0);
        check("rst_gpio_dir", 32'(gpio_dir), 32'h0);
        check("rst_alt_in",   32'(gpio_alt_in), 32'h0);
        check("rst_irq",      32'(irq), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // ---------------- register table ----------------
        for (int a = 0; a < 16; a++) add(1'b0, 4'(a), 32'h0, 32'h0);
        add(1'b1, 4'd0,  32'hFFFF_FFFF, 32'h0000_00FF); // PADDIR, upper bits dropped
        add(1'b1, 4'd2,  32'h0000_000F, 32'h0000_000F); // PADOUT
        add(1'b1, 4'd9,  32'h0000_0030, 32'h0000_0000); // OUTSET reads 0
        add(1'b1, 4'd10, 32'h0000_0001, 32'h0000_0000); // OUTCLR reads 0
        add(1'b0, 4'd2,  32'h0,         32'h0000_003E); // 0x0F|0x30&~0x01
        add(1'b1, 4'd3,  32'h0,         32'h0);
        add(1'b1, 4'd4,  32'h0000_01A5, 32'h0000_00A5);
        add(1'b1, 4'd4,  32'h0,         32'h0);
        add(1'b1, 4'd5,  32'h0000_005A, 32'h0000_005A);
        add(1'b1, 4'd5,  32'h0,         32'h0);
        add(1'b1, 4'd7,  32'h0000_013C, 32'h0000_003C);
        add(1'b1, 4'd7,  32'h0,         32'h0);
        add(1'b1, 4'd8,  32'h0000_00C3, 32'h0000_00C3);
        add(1'b1, 4'd8,  32'h0,         32'h0);
        add(1'b1, 4'd13, 32'hFFFF_FFFF, 32'h0);         // unmapped
        add(1'b1, 4'd11, 32'h0000_00FF, c_DBEN_RD);
        add(1'b1, 4'd11, 32'h0,         32'h0);
        add(1'b1, 4'd12, 32'hABCD_1234, c_DBDIV_RD);
        add(1'b1, 4'd12, 32'h0,         32'h0);
        add(1'b1, 4'd6,  32'h0000_00FF, 32'h0);         // W1C of empty status

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].do_wr) wr(tbl[i].addr, tbl[i].wdata);
            rd(tbl[i].addr, v);
            check($sformatf("tbl[%0d] addr %0d", i, tbl[i].addr), v, tbl[i].exp);
        end

        check("padout_pins", 32'(gpio_out), 32'h0000_003E);
        check("paddir_pins", 32'(gpio_dir), 32'h0000_00FF);

        // ---------------- pin 2 rising edge ----------------
        wr(4'd5, 32'h04);
        wr(4'd4, 32'h00);
        wr(4'd3, 32'h04);
        @(negedge clk);
        gpio_in[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rd_check("padin_after_sync", 4'd1, 32'h04);
        check("irq_before_edge", 32'(irq), 32'h0);
        @(negedge clk);
        check("irq_rise", 32'(irq), 32'h1);
        rd_check("intstat_rise", 4'd6, 32'h04);
        gpio_in[2] = 1'b0;
        repeat (4) @(negedge clk);
        rd_check("intstat_sticky", 4'd6, 32'h04);
        wr(4'd6, 32'h04);
        check("irq_after_w1c", 32'(irq), 32'h0);
        rd_check("intstat_w1c", 4'd6, 32'h0);

        // ---------------- pin 5 level-low ----------------
        wr(4'd4, 32'h20);
        wr(4'd3, 32'h24);
        @(negedge clk);
        rd_check("intstat_level_low", 4'd6, 32'h20);
        wr(4'd6, 32'h20);
        rd_check("intstat_level_reset", 4'd6, 32'h20);
        check("irq_level", 32'(irq), 32'h1);

        // W1C lands on the same edge as a pin 2 rising edge
        @(negedge clk);
        gpio_in[2] = 1'b1;
        @(negedge clk);
        wr(4'd6, 32'h04);
        rd_check("intstat_set_wins", 4'd6, 32'h24);

        // level absent -> W1C holds
        gpio_in[5] = 1'b1;
        repeat (3) @(negedge clk);
        wr(4'd6, 32'h24);
        rd_check("intstat_clear_all", 4'd6, 32'h0);
        check("irq_cleared", 32'(irq), 32'h0);

        // clearing INTEN leaves INTSTAT alone but masks irq
        gpio_in[5] = 1'b0;
        repeat (4) @(negedge clk);
        wr(4'd3, 32'h00);
        rd_check("intstat_after_inten_clr", 4'd6, 32'h20);
        check("irq_masked", 32'(irq), 32'h0);

        // ---------------- pin 3 falling edge ----------------
        wr(4'd5, 32'h0C);
        wr(4'd4, 32'h28);
        wr(4'd3, 32'h08);
        gpio_in[3] = 1'b1;
        repeat (4) @(negedge clk);
        rd_check("intstat_fall_on_rise", 4'd6, 32'h20);
        gpio_in[3] = 1'b0;
        repeat (4) @(negedge clk);
        rd_check("intstat_fall", 4'd6, 32'h28);
        check("irq_fall", 32'(irq), 32'h1);
        wr(4'd3, 32'h00);
        wr(4'd6, 32'hFF);

        // ---------------- alternate-function mux ----------------
        wr(4'd2, 32'h00);
        wr(4'd7, 32'h03);
        wr(4'd8, 32'h02);
        alt0_out = 8'h01;
        alt1_out = 8'h02;
        alt0_dir = 8'h00;
        alt1_dir = 8'h02;
        #1;
        check("alt_out", 32'(gpio_out), 32'h03);
        check("alt_dir_a", 32'(gpio_dir), 32'hFE);
        alt0_dir = 8'h01;
        alt1_dir = 8'h00;
        #1;
        check("alt_dir_b", 32'(gpio_dir), 32'hFD);
        check("alt_in", 32'(gpio_alt_in), 32'h04);
        wr(4'd7, 32'h00);
        check("mux_back_out", 32'(gpio_out), 32'h00);
        check("mux_back_dir", 32'(gpio_dir), 32'hFF);

`ifdef GPIO_DEBOUNCE_EN
        // ---------------- debounce ----------------
        gpio_in = '0;
        repeat (4) @(negedge clk);
        wr(4'd11, 32'h01);
        wr(4'd12, 32'd9);
        gpio_in[0] = 1'b1;
        seen = 0;
        for (int c = 0; c < 45; c++) begin
            if (c == 30) gpio_in[0] = 1'b0;
            @(negedge clk);
            rd(4'd1, v);
            if (v[0]) seen = 1;
        end
        check("db_glitch_filtered", 32'(seen), 32'h0);

        // reset part-way through a count
        wr(4'd12, 32'd9);
        gpio_in[0] = 1'b1;
        repeat (25) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rd_check("db_padin_in_reset", 4'd1, 32'h0);
        gpio_in[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        wr(4'd11, 32'h01);
        wr(4'd12, 32'd9);
        gpio_in[0] = 1'b1;
        seen = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            rd(4'd1, v);
            if (v[0]) begin
                seen = c;
                break;
            end
        end
        n_vec++;
        if (seen < 40 || seen > 40 + 10 + SYNC_STAGES) begin
            n_err++;
            $display("FAIL db_accept_cycle: got %0d cycles required 40..%0d (0 = never)",
                     seen, 40 + 10 + SYNC_STAGES);
        end

        // bypass: DBEN=0 follows the synchroniser directly
        wr(4'd11, 32'h00);
        gpio_in[0] = 1'b0;
        repeat (SYNC_STAGES) @(negedge clk);
        rd_check("db_bypass", 4'd1, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
